seven_seg_scan_driver: RTL

- Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus.
- Takes a packed BCD word and decodes each nibble with the team's standard BCD-to-segment pattern.
- Scans the digits with a programmable per-digit dwell and an anti-ghosting blank window.
- Input is double-buffered so a frame never tears; sits between the counter/datapath blocks and the board display pins.

---
 rtl/seven_seg_scan_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Double-buffered packed BCD input, programmable per-digit dwell and blank window,
// configurable segment/anode polarity.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    // BCD to segment pattern {a..g}, codes above 9 are blank.
    function automatic logic [6:0] decode_bcd(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b0011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] s);
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_polarity(input logic [NUM_DIGITS-1:0] a);
        return (AN_ACTIVE_LOW != 0) ? ~a : a;
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic                    slot_end;
    logic                    frame_end;
    logic                    in_blank;
    logic [3:0]              cur_nibble;
    logic                    digit_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              seg_p1;
    logic [NUM_DIGITS-1:0]   digit_sel_p1;
    logic                    frame_tick_p1;

    assign slot_end   = en && (cnt == CNT_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign in_blank   = int'(cnt) < BLANK_CYCLES;
    assign cur_nibble = disp_reg[{idx, 2'b00} +: 4];
    assign onehot     = NUM_DIGITS'(1) << idx;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  seen_nz;

    // Mark zero digits above the most significant non-zero digit; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (disp_reg[4*k +: 4] != 4'd0) seen_nz = 1'b1;
            lz_mask[k] = ~seen_nz;
        end
    end

    assign digit_blank = lz_mask[idx];
`else
    assign digit_blank = 1'b0;
`endif

    // Slot prescaler and digit index; held at the frame start while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: the displayed word only changes at a frame boundary, newest load wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg   <= '0;
            pend_valid <= 1'b0;
            disp_reg   <= '0;
        end else if (load && frame_end) begin
            pend_reg   <= data_in;
            pend_valid <= 1'b0;
            disp_reg   <= data_in;
        end else if (frame_end && pend_valid) begin
            pend_valid <= 1'b0;
            disp_reg   <= pend_reg;
        end else if (load) begin
            pend_reg   <= data_in;
            pend_valid <= 1'b1;
        end
    end

    // ---- stage p1: registered display outputs, polarity applied last ----
    // Output register: blank window and disable force everything off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p1        <= SEG_OFF;
            digit_sel_p1  <= AN_OFF;
            frame_tick_p1 <= 1'b0;
        end else begin
            frame_tick_p1 <= frame_end;
            if (!en || in_blank) begin
                seg_p1       <= SEG_OFF;
                digit_sel_p1 <= AN_OFF;
            end else begin
                seg_p1       <= seg_polarity(digit_blank ? 7'b0000000 : decode_bcd(cur_nibble));
                digit_sel_p1 <= an_polarity(onehot);
            end
        end
    end

    assign seg        = seg_p1;
    assign digit_sel  = digit_sel_p1;
    assign frame_tick = frame_tick_p1;

endmodule
